// File: rtl/sat_mac_pkg.sv
// Shared definitions for the saturating multiply-accumulate unit:
// command opcodes, controller state encoding and signed range limits.
package sat_mac_pkg;

    // Command opcodes carried on in_op (the 2-bit space is fully used).
    typedef enum logic [1:0] {
        OP_CLR  = 2'b00,
        OP_ADD  = 2'b01,
        OP_MAC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_ACC  = 2'b10,
        S_RESP = 2'b11
    } state_e;

    // Bit pattern of the most positive WIDTH-bit signed value, 2^(WIDTH-1)-1.
    function automatic logic [63:0] sat_p_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative WIDTH-bit signed value, -2^(WIDTH-1).
    // Read as unsigned it is also the magnitude of that value.
    function automatic logic [63:0] sat_n_max(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/no_overflow_adder.sv
// Combinational signed adder that clamps to the representable range and
// reports which direction it clamped in.
module no_overflow_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             po,
    output logic             no
);

    logic [WIDTH-1:0] raw;

    // Overflow shows up as operands of equal sign giving a result of the other sign.
    always_comb begin
        raw = a + b;
        po  = ~a[WIDTH-1] & ~b[WIDTH-1] &  raw[WIDTH-1];
        no  =  a[WIDTH-1] &  b[WIDTH-1] & ~raw[WIDTH-1];
        if (po) begin
            sum = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (no) begin
            sum = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sum = raw;
        end
    end

endmodule

// File: rtl/seq_signed_multiplier.sv
// Iterative signed multiplier: unsigned shift-add over the operand
// magnitudes for WIDTH cycles, sign applied at the end, result clamped to
// the WIDTH-bit signed range.
// done is high during the final iteration; product/prod_po/prod_no are
// valid from the following cycle and held until the next start.
module seq_signed_multiplier
    import sat_mac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             prod_po,
    output logic             prod_no
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] P_MAX = WIDTH'(sat_p_max(WIDTH));
    localparam logic [WIDTH-1:0] N_MAX = WIDTH'(sat_n_max(WIDTH));

    logic                 running;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   full;
    logic [WIDTH-1:0]     low;
    logic                 clamp_po;
    logic                 clamp_no;
    logic [WIDTH-1:0]     clamped;

    // Magnitude of a signed value; the most negative value maps onto itself,
    // which read as unsigned is exactly its magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    assign done = running && (cnt == CW'(WIDTH - 1));

    // One shift-add step, plus the signed/clamped view of the running sum.
    always_comb begin
        addend   = mag_b[cnt] ? ({{WIDTH{1'b0}}, mag_a} << cnt) : '0;
        full     = partial + addend;
        low      = full[WIDTH-1:0];
        clamp_po = ~neg && (full > {{WIDTH{1'b0}}, P_MAX});
        clamp_no =  neg && (full > {{WIDTH{1'b0}}, N_MAX});
        if (clamp_po) begin
            clamped = P_MAX;
        end else if (clamp_no) begin
            clamped = N_MAX;
        end else if (neg) begin
            clamped = ~low + 1'b1;
        end else begin
            clamped = low;
        end
    end

    // Latch magnitudes and sign on start, iterate, and capture the clamped result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            neg     <= 1'b0;
            partial <= '0;
            product <= '0;
            prod_po <= 1'b0;
            prod_no <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            mag_a   <= magnitude(a);
            mag_b   <= magnitude(b);
            neg     <= a[WIDTH-1] ^ b[WIDTH-1];
            partial <= '0;
        end else if (running) begin
            partial <= full;
            cnt     <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
                product <= clamped;
                prod_po <= clamp_po;
                prod_no <= clamp_no;
            end
        end
    end

endmodule

// File: rtl/sat_mac_accumulator.sv
// Multi-cycle saturating multiply-accumulate unit. One command at a time:
// accept, optionally multiply, update the accumulator, then hold the result
// until the consumer takes it. acc and the sticky flags are registered and
// change only on the ACC update edge, on CLR/LOAD, or on reset.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer keeps valid and its payload
// steady until that edge; ready never depends combinationally on valid.
module sat_mac_accumulator
    import sat_mac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             sat_po,
    output logic             sat_no
);

    // Controller state, kept as a named signal so checkers can bind to it.
    state_e           state;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;

    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             mul_po;
    logic             mul_no;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_po;
    logic             add_no;

    assign accept    = (state == S_IDLE) && in_valid && in_ready;
    assign mul_start = accept && (op_e'(in_op) == OP_MAC);
    assign add_b     = (op_q == OP_MAC) ? mul_product : a_q;

    seq_signed_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_product),
        .prod_po (mul_po),
        .prod_no (mul_no)
    );

    no_overflow_adder #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (acc),
        .b   (add_b),
        .sum (add_sum),
        .po  (add_po),
        .no  (add_no)
    );

    // Command FSM with registered handshake outputs and accumulator state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_CLR;
            a_q       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
            sat_po    <= 1'b0;
            sat_no    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        op_q     <= op_e'(in_op);
                        a_q      <= in_a;
                        in_ready <= 1'b0;
                        state    <= (op_e'(in_op) == OP_MAC) ? S_MUL : S_ACC;
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    case (op_q)
                        OP_CLR: begin
                            acc    <= '0;
                            sat_po <= 1'b0;
                            sat_no <= 1'b0;
                        end
                        OP_LOAD: begin
                            acc    <= a_q;
                            sat_po <= 1'b0;
                            sat_no <= 1'b0;
                        end
                        OP_ADD: begin
                            acc    <= add_sum;
                            sat_po <= sat_po | add_po;
                            sat_no <= sat_no | add_no;
                        end
                        default: begin
                            acc    <= add_sum;
                            sat_po <= sat_po | add_po | mul_po;
                            sat_no <= sat_no | add_no | mul_no;
                        end
                    endcase
                    out_valid <= 1'b1;
                    state     <= S_RESP;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sat_mac_accumulator.sv
// Directed and randomized bench for sat_mac_accumulator at WIDTH=8.
// Expected values come from an integer-arithmetic model of the command set.
module tb_sat_mac_accumulator;
    import sat_mac_pkg::*;

    localparam int W    = 8;
    localparam int PMAX = 127;
    localparam int NMAX = -128;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_op = 2'b00;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] acc;
    logic         sat_po;
    logic         sat_no;

    int n_tests = 0;
    int n_fail  = 0;
    int m_acc   = 0;
    bit m_po    = 1'b0;
    bit m_no    = 1'b0;
    int last_wait;

    sat_mac_accumulator #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .sat_po    (sat_po),
        .sat_no    (sat_no)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic with clamping.
    task automatic model_add(input int v);
        int s;
        s = m_acc + v;
        if (s > PMAX) begin
            m_acc = PMAX;
            m_po  = 1'b1;
        end else if (s < NMAX) begin
            m_acc = NMAX;
            m_no  = 1'b1;
        end else begin
            m_acc = s;
        end
    endtask

    task automatic model_apply(input logic [1:0] op, input int a, input int b);
        int p;
        case (op)
            OP_CLR: begin
                m_acc = 0; m_po = 1'b0; m_no = 1'b0;
            end
            OP_LOAD: begin
                m_acc = a; m_po = 1'b0; m_no = 1'b0;
            end
            OP_ADD: model_add(a);
            default: begin
                p = a * b;
                if (p > PMAX) begin
                    p = PMAX; m_po = 1'b1;
                end else if (p < NMAX) begin
                    p = NMAX; m_no = 1'b1;
                end
                model_add(p);
            end
        endcase
    endtask

    // Driver: issue one command, check latency and result, optionally hold
    // off the consumer for 'hold' cycles (with a competing request if pend),
    // then retire it. Called and returns at a falling edge.
    task automatic run_cmd(input logic [1:0] op, input int a, input int b,
                           input int hold, input bit pend);
        int lat;
        int exp_edge;
        last_wait = 0;
        while (!in_ready && last_wait < 50) begin
            @(negedge clk);
            last_wait++;
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a[W-1:0];
        in_b     = b[W-1:0];
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        exp_edge = (op == OP_MAC) ? W + 2 : 2;
        chk("out_valid_edge", lat + 1, exp_edge);
        model_apply(op, a, b);
        chk("acc", acc, m_acc & MASK);
        chk("sat_po", sat_po, m_po);
        chk("sat_no", sat_no, m_no);
        for (int i = 0; i < hold; i++) begin
            if (pend) begin
                in_valid = 1'b1;
                in_op    = OP_LOAD;
                in_a     = 'd77;
            end
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_acc", acc, m_acc & MASK);
            chk("hold_flags", {sat_po, sat_no}, {m_po, m_no});
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    initial begin
        int stale;
        // Reset.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_acc", acc, 0);
        chk("rst_flags", {sat_po, sat_no}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Saturating add, positive side.
        run_cmd(OP_LOAD, 100, 0, 0, 0);
        run_cmd(OP_ADD, 27, 0, 0, 0);
        run_cmd(OP_ADD, 1, 0, 0, 0);
        run_cmd(OP_ADD, -5, 0, 0, 0);

        // Exact MAC.
        run_cmd(OP_CLR, 0, 0, 0, 0);
        run_cmd(OP_LOAD, 10, 0, 0, 0);
        run_cmd(OP_MAC, 7, -3, 0, 0);

        // Product clamps.
        run_cmd(OP_CLR, 0, 0, 0, 0);
        run_cmd(OP_MAC, 12, -11, 0, 0);
        run_cmd(OP_CLR, 0, 0, 0, 0);
        run_cmd(OP_MAC, -128, -128, 0, 0);
        run_cmd(OP_CLR, 0, 0, 0, 0);

        // Backpressure with a competing request, then immediate next accept.
        run_cmd(OP_ADD, 3, 0, 5, 1);
        run_cmd(OP_ADD, 4, 0, 0, 0);
        chk("accept_next_cycle", last_wait, 0);

        // Reset in the middle of a MAC.
        run_cmd(OP_LOAD, 33, 0, 0, 0);
        in_valid = 1'b1;
        in_op    = OP_MAC;
        in_a     = 'd50;
        in_b     = 'd50;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_acc", acc, 0);
        chk("midrst_flags", {sat_po, sat_no}, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0; m_po = 1'b0; m_no = 1'b0;
        stale = 0;
        for (int i = 0; i < 2 * W + 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale_valid", stale, 0);
        run_cmd(OP_ADD, 5, 0, 0, 0);

        // Saturating add, negative side.
        run_cmd(OP_LOAD, -100, 0, 0, 0);
        run_cmd(OP_ADD, -100, 0, 0, 0);
        run_cmd(OP_MAC, -1, 1, 0, 0);

        // Random command stream.
        for (int i = 0; i < 40; i++) begin
            int op;
            int ra;
            int rb;
            op = $urandom_range(0, 3);
            ra = int'($urandom_range(0, 255)) - 128;
            rb = int'($urandom_range(0, 255)) - 128;
            run_cmd(op[1:0], ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
